sv32_ptw: RTL and testbench

- Sv32 page-table walker with a small fully-associative TLB.
- Initiator side of the data memory's page-table read ports. It drives the level-1 and level-0 PTE addresses, consumes the returned PTEs, and produces the physical address plus a page-fault flag.
- The fault flag feeds the memory's write-suppress input.
- Sits between the LSU address stage and data memory; M mode and bare mode bypass translation.

---
 rtl/sv32_ptw.sv | 219 +++++++++++++++++++++
 tb/tb_sv32_ptw.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv32_ptw.sv
// Sv32 page-table walker fronted by a small fully-associative TLB.
// M-mode and bare-mode requests bypass translation entirely.
module sv32_ptw #(
    parameter int TLB_ENTRIES = 4,
    parameter int PTESIZE     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_vaddr,
    input  logic        req_store,
    input  logic        priv_m,
    input  logic [31:0] satp,
    input  logic        sfence,
    output logic        pte_en,
    output logic [31:0] pte_addr1,
    input  logic [31:0] pte_rdata1,
    output logic [31:0] pte_addr2,
    input  logic [31:0] pte_rdata2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_paddr,
    output logic        page_fault
);

    localparam int IW = $clog2(TLB_ENTRIES);
    localparam logic [31:0] PTE_SZ = 32'(PTESIZE);

    typedef enum logic [2:0] {IDLE, LOOKUP, L1, L0, RESP} state_t;

    state_t                 state;
    logic [31:0]            vaddr_q;
    logic                   store_q;
    logic [19:0]            root_q;
    logic                   flushed_q;
    logic [IW-1:0]          ptr;
    logic [TLB_ENTRIES-1:0] tlb_v;
    logic [TLB_ENTRIES-1:0] tlb_sp;
    logic [TLB_ENTRIES-1:0] tlb_r;
    logic [TLB_ENTRIES-1:0] tlb_w;
    logic [TLB_ENTRIES-1:0] tlb_d;
    logic [19:0]            tlb_vpn [TLB_ENTRIES];
    logic [21:0]            tlb_ppn [TLB_ENTRIES];

    logic        hit;
    logic        h_sp;
    logic        h_r;
    logic        h_w;
    logic        h_d;
    logic [21:0] h_ppn;
    logic        hit_fault;
    logic [31:0] hit_paddr;
    logic        l1_ptr;
    logic        l1_fault;
    logic [31:0] l1_paddr;
    logic [31:0] l0_addr;
    logic        l0_fault;
    logic [31:0] l0_paddr;
    logic        fill_en;
    logic        fill_sp;
    logic [31:0] fill_pte;
    logic        unused_ok;

    function automatic logic perm_fault(input logic [31:0] pte,
                                        input logic        st);
        return !pte[6] || (st ? (!pte[2] || !pte[7]) : !pte[1]);
    endfunction

    assign req_ready = (state == IDLE);

    assign unused_ok = ^{satp[30:20], h_ppn[21:20],
                         pte_rdata1[31:30], pte_rdata1[9:8], pte_rdata1[5:4],
                         pte_rdata2[31:30], pte_rdata2[9:8], pte_rdata2[5:4]};

    always_comb begin
        hit   = 1'b0;
        h_sp  = 1'b0;
        h_r   = 1'b0;
        h_w   = 1'b0;
        h_d   = 1'b0;
        h_ppn = '0;
        // descending scan leaves the lowest matching index in place
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (tlb_v[i] && (tlb_sp[i] ?
                    tlb_vpn[i][19:10] == vaddr_q[31:22] :
                    tlb_vpn[i] == vaddr_q[31:12])) begin
                hit   = 1'b1;
                h_sp  = tlb_sp[i];
                h_r   = tlb_r[i];
                h_w   = tlb_w[i];
                h_d   = tlb_d[i];
                h_ppn = tlb_ppn[i];
            end
        end
        hit_fault = store_q ? !(h_w && h_d) : !h_r;
        hit_paddr = h_sp ? {h_ppn[19:10], vaddr_q[21:0]}
                         : {h_ppn[19:0], vaddr_q[11:0]};

        l1_ptr   = !pte_rdata1[1] && !pte_rdata1[3];
        l1_fault = !pte_rdata1[0]
                || (!pte_rdata1[1] && pte_rdata1[2])
                || (!l1_ptr && (pte_rdata1[19:10] != 10'd0
                    || perm_fault(pte_rdata1, store_q)));
        l1_paddr = {pte_rdata1[29:20], vaddr_q[21:0]};
        l0_addr  = {pte_rdata1[29:10], 12'b0}
                 + {22'b0, vaddr_q[21:12]} * PTE_SZ;

        l0_fault = !pte_rdata2[0]
                || (!pte_rdata2[1] && pte_rdata2[2])
                || (!pte_rdata2[1] && !pte_rdata2[3])
                || perm_fault(pte_rdata2, store_q);
        l0_paddr = {pte_rdata2[29:10], vaddr_q[11:0]};

        fill_sp  = (state == L1);
        fill_pte = fill_sp ? pte_rdata1 : pte_rdata2;
        // a flush seen during this walk (or right now) suppresses its fill
        fill_en  = !sfence && !flushed_q
                && ((state == L1 && !l1_fault && !l1_ptr)
                 || (state == L0 && !l0_fault));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vaddr_q    <= '0;
            store_q    <= 1'b0;
            root_q     <= '0;
            flushed_q  <= 1'b0;
            ptr        <= '0;
            tlb_v      <= '0;
            resp_valid <= 1'b0;
            resp_paddr <= '0;
            page_fault <= 1'b0;
            pte_en     <= 1'b0;
            pte_addr1  <= '0;
            pte_addr2  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        vaddr_q   <= req_vaddr;
                        store_q   <= req_store;
                        root_q    <= satp[19:0];
                        flushed_q <= 1'b0;
                        if (priv_m || !satp[31]) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_paddr <= req_vaddr;
                            page_fault <= 1'b0;
                        end else begin
                            state <= LOOKUP;
                        end
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_paddr <= hit_fault ? 32'd0 : hit_paddr;
                        page_fault <= hit_fault;
                    end else begin
                        state     <= L1;
                        pte_en    <= 1'b1;
                        pte_addr1 <= {root_q, 12'b0}
                                   + {22'b0, vaddr_q[31:22]} * PTE_SZ;
                    end
                end
                L1: begin
                    pte_addr1 <= '0;
                    if (!l1_fault && l1_ptr) begin
                        state     <= L0;
                        pte_addr2 <= l0_addr;
                    end else begin
                        state      <= RESP;
                        pte_en     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_paddr <= l1_fault ? 32'd0 : l1_paddr;
                        page_fault <= l1_fault;
                    end
                end
                L0: begin
                    state      <= RESP;
                    pte_en     <= 1'b0;
                    pte_addr2  <= '0;
                    resp_valid <= 1'b1;
                    resp_paddr <= l0_fault ? 32'd0 : l0_paddr;
                    page_fault <= l0_fault;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_paddr <= '0;
                        page_fault <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (fill_en) begin
                tlb_v[ptr]   <= 1'b1;
                tlb_sp[ptr]  <= fill_sp;
                tlb_r[ptr]   <= fill_pte[1];
                tlb_w[ptr]   <= fill_pte[2];
                tlb_d[ptr]   <= fill_pte[7];
                tlb_vpn[ptr] <= vaddr_q[31:12];
                tlb_ppn[ptr] <= fill_pte[31:10];
                ptr          <= ptr + 1'b1;
            end

            if (sfence) begin
                tlb_v <= '0;
                if (state != IDLE) flushed_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sv32_ptw.sv
// Scoreboard bench for sv32_ptw: directed walks, faults, bypass,
// backpressure, replacement, reset mid-walk, then random traffic.
module tb_sv32_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic        req_store;
    logic        priv_m;
    logic [31:0] satp;
    logic        sfence;
    logic        pte_en;
    logic [31:0] pte_addr1;
    logic [31:0] pte_rdata1;
    logic [31:0] pte_addr2;
    logic [31:0] pte_rdata2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_paddr;
    logic        page_fault;

    sv32_ptw #(.TLB_ENTRIES(4), .PTESIZE(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_vaddr(req_vaddr), .req_store(req_store),
        .priv_m(priv_m), .satp(satp), .sfence(sfence),
        .pte_en(pte_en),
        .pte_addr1(pte_addr1), .pte_rdata1(pte_rdata1),
        .pte_addr2(pte_addr2), .pte_rdata2(pte_rdata2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_paddr(resp_paddr), .page_fault(page_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] paddr;
        logic        fault;
        int          lat;
        int          reads;
        logic [31:0] a1;
        logic [31:0] a2;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] mem [4096];

    // reference TLB: FIFO replacement, pointer survives sfence
    bit          mv [4];
    logic [19:0] mvpn [4];
    logic [21:0] mppn [4];
    bit          msp [4];
    bit          mr [4];
    bit          mw [4];
    bit          md [4];
    int          mptr = 0;

    localparam logic [31:0] S = 32'h8000_0010;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd(input logic [31:0] a);
        int idx;
        if (a >= 32'h10000 && a < 32'h14000) begin
            idx = int'((a - 32'h10000) >> 2);
            return mem[idx];
        end
        return 32'h0;
    endfunction

    assign pte_rdata1 = rd(pte_addr1);
    assign pte_rdata2 = rd(pte_addr2);

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
        int idx;
        idx = int'((a - 32'h10000) >> 2);
        mem[idx] = d;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit perm_ok(input logic [31:0] p, input bit st);
        return p[6] && (st ? (p[2] && p[7]) : p[1]);
    endfunction

    task automatic model_fill(input logic [31:0] va, input logic [31:0] p,
                              input bit sp);
        mv[mptr]   = 1'b1;
        mvpn[mptr] = va[31:12];
        mppn[mptr] = p[31:10];
        msp[mptr]  = sp;
        mr[mptr]   = p[1];
        mw[mptr]   = p[2];
        md[mptr]   = p[7];
        mptr       = (mptr + 1) % 4;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    endtask

    task automatic predict(input logic [31:0] va, input bit st, input bit pm,
                           input logic [31:0] sp, input bit sf,
                           output exp_t e);
        logic [63:0] t;
        logic [31:0] p;
        logic [31:0] q;
        logic [21:0] ppn;
        int          hi;
        bit          ok;
        e = '{default: 0};
        hi = -1;
        if (pm || !sp[31]) begin
            e.paddr = va;
            e.lat   = 1;
        end else begin
            for (int i = 0; i < 4; i++)
                if (hi < 0 && mv[i] && (msp[i] ? mvpn[i][19:10] == va[31:22]
                                               : mvpn[i] == va[31:12]))
                    hi = i;
            if (hi >= 0) begin
                e.lat = 2;
                ok = st ? (mw[hi] && md[hi]) : mr[hi];
                if (ok) begin
                    if (msp[hi])
                        t = (64'(mppn[hi] >> 10) << 22) + 64'(va % 32'h400000);
                    else
                        t = (64'(mppn[hi]) << 12) + 64'(va % 32'h1000);
                    e.paddr = t[31:0];
                end
                e.fault = !ok;
            end else begin
                t = (64'(sp[21:0]) << 12) + 64'(va >> 22) * 4;
                e.a1 = t[31:0];
                e.reads = 1;
                e.lat = 3;
                p = rd(e.a1);
                ppn = p[31:10];
                if (!p[0] || (p[2] && !p[1])) begin
                    e.fault = 1'b1;
                end else if (!p[1] && !p[3]) begin
                    e.reads = 2;
                    e.lat = 4;
                    t = (64'(ppn) << 12) + 64'((va >> 12) % 1024) * 4;
                    e.a2 = t[31:0];
                    q = rd(e.a2);
                    if (!q[0] || (q[2] && !q[1]) || (!q[1] && !q[3])
                            || !perm_ok(q, st)) begin
                        e.fault = 1'b1;
                    end else begin
                        t = (64'(q[31:10]) << 12) + 64'(va % 32'h1000);
                        e.paddr = t[31:0];
                        if (!sf) model_fill(va, q, 1'b0);
                    end
                end else if (ppn % 1024 != 0 || !perm_ok(p, st)) begin
                    e.fault = 1'b1;
                end else begin
                    t = (64'(ppn >> 10) << 22) + 64'(va % 32'h400000);
                    e.paddr = t[31:0];
                    if (!sf) model_fill(va, p, 1'b1);
                end
            end
        end
        if (sf) model_flush();
    endtask

    task automatic issue(input logic [31:0] va, input bit st, input bit pm,
                         input logic [31:0] sp, input bit sf);
        exp_t e;
        int   t;
        predict(va, st, pm, sp, sf, e);
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        req_vaddr = va;
        req_store = st;
        priv_m    = pm;
        satp      = sp;
        req_valid = 1'b1;
        e.acc     = cyc + 1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (sf) begin
            sfence = 1'b1;
            @(posedge clk); #1;
            sfence = 1'b0;
        end
        t = 0;
        while (sb_q.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: no response for vaddr %h", va);
            sb_q.delete();
        end
    endtask

    task automatic do_sfence();
        sfence = 1'b1;
        @(posedge clk); #1;
        sfence = 1'b0;
        model_flush();
    endtask

    // monitor: first sighting checks value/latency/reads, then stability
    int          seen = 0;
    int          reads = 0;
    logic [31:0] held_p;
    logic        held_f;

    always @(negedge clk) begin
        if (rst) begin
            seen  = 0;
            reads = 0;
        end else begin
            if (pte_en) begin
                reads++;
                if (sb_q.size() > 0) begin
                    if (pte_addr1 != 32'd0)
                        chk("pte_addr1", pte_addr1, sb_q[0].a1);
                    else
                        chk("pte_addr2", pte_addr2, sb_q[0].a2);
                end
            end
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got %h want none",
                             resp_paddr);
                end else if (seen == 0) begin
                    chk("paddr", resp_paddr, sb_q[0].paddr);
                    chk("fault", 32'(page_fault), 32'(sb_q[0].fault));
                    chk("latency", 32'(cyc - sb_q[0].acc + 1),
                        32'(sb_q[0].lat));
                    chk("pte_reads", 32'(reads), 32'(sb_q[0].reads));
                    chk("req_ready_busy", 32'(req_ready), 32'd0);
                    held_p = resp_paddr;
                    held_f = page_fault;
                    seen = 1;
                end else begin
                    chk("hold_paddr", resp_paddr, held_p);
                    chk("hold_fault", 32'(page_fault), 32'(held_f));
                    chk("req_ready_busy", 32'(req_ready), 32'd0);
                end
                if (resp_ready) begin
                    seen  = 0;
                    reads = 0;
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                end
            end
        end
    end

    // consumer: random readiness, or a 5-cycle stall when bp_on
    bit bp_on = 1'b0;
    int hold_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (!bp_on) begin
            hold_cnt = 0;
            resp_ready = ($urandom_range(0, 3) != 0);
        end else if (hold_cnt < 5) begin
            resp_ready = 1'b0;
            if (resp_valid) hold_cnt++;
        end else begin
            resp_ready = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    function automatic logic [31:0] gen_l1();
        unique case ($urandom_range(0, 5))
            0, 1, 2: return (32'(32'h11 + $urandom_range(0, 2)) << 10) | 32'h1;
            3: return (32'($urandom_range(0, 7)) << 20)
                    | ($urandom & 32'hC6) | 32'h43;
            4: return (32'($urandom_range(1, 1023)) << 10) | 32'hCF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] gen_l0();
        logic [31:0] lo;
        if ($urandom_range(0, 3) != 0) lo = 32'hC3 | ($urandom & 32'h0C);
        else lo = $urandom & 32'hFF;
        return (32'($urandom_range(0, 32'hFFFFF)) << 10) | lo;
    endfunction

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_vaddr = '0;
        req_store = 1'b0;
        priv_m = 1'b0;
        satp = '0;
        sfence = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_fault", 32'(page_fault), 32'd0);
        chk("rst_paddr", resp_paddr, 32'd0);
        chk("rst_pte_en", 32'(pte_en), 32'd0);
        chk("rst_addr1", pte_addr1, 32'd0);
        chk("rst_addr2", pte_addr2, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        mem_wr(32'h10004, 32'h0000_4401);
        mem_wr(32'h11004, 32'h0000_88C7);
        mem_wr(32'h10008, 32'h0010_0043);
        issue(32'h0040_1234, 1'b0, 1'b0, S, 1'b0);
        issue(32'h0040_1234, 1'b1, 1'b0, S, 1'b0);
        do_sfence();
        issue(32'h0040_1234, 1'b1, 1'b0, S, 1'b0);

        issue(32'h0080_0ABC, 1'b0, 1'b0, S, 1'b0);
        issue(32'h0080_0ABC, 1'b1, 1'b0, S, 1'b0);
        do_sfence();
        mem_wr(32'h10008, 32'h0010_0443);
        issue(32'h0080_0ABC, 1'b0, 1'b0, S, 1'b0);
        issue(32'h0080_0ABC, 1'b0, 1'b0, S, 1'b0);

        do_sfence();
        mem_wr(32'h11004, 32'h0000_88C6);
        issue(32'h0040_1234, 1'b0, 1'b0, S, 1'b0);
        mem_wr(32'h11004, 32'h0000_8887);
        issue(32'h0040_1234, 1'b1, 1'b0, S, 1'b0);
        mem_wr(32'h10004, 32'h0000_4405);
        issue(32'h0040_1234, 1'b0, 1'b0, S, 1'b0);

        issue(32'hDEAD_BEE0, 1'b0, 1'b1, S, 1'b0);
        issue(32'hDEAD_BEE0, 1'b1, 1'b0, 32'h0000_0010, 1'b0);

        mem_wr(32'h10004, 32'h0000_4401);
        mem_wr(32'h11004, 32'h0000_88C7);
        bp_on = 1'b1;
        issue(32'h0040_1234, 1'b0, 1'b0, S, 1'b0);
        bp_on = 1'b0;

        do_sfence();
        for (int k = 0; k < 5; k++)
            mem_wr(32'h11000 + 32'(4 * k), (32'(32'h30 + k) << 10) | 32'hC7);
        for (int k = 0; k < 5; k++)
            issue(32'h0040_0000 | (32'(k) << 12), 1'b0, 1'b0, S, 1'b0);
        issue(32'h0040_0010, 1'b0, 1'b0, S, 1'b0);
        issue(32'h0040_4010, 1'b1, 1'b0, S, 1'b0);

        do_sfence();
        issue(32'h0040_1020, 1'b0, 1'b0, S, 1'b1);
        issue(32'h0040_1020, 1'b0, 1'b0, S, 1'b0);

        // reset while the walker sits in L0
        do_sfence();
        issue(32'h0040_2000, 1'b0, 1'b0, S, 1'b0);
        req_vaddr = 32'h0040_3000;
        req_store = 1'b0;
        priv_m = 1'b0;
        satp = S;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        begin
            int t;
            t = 0;
            while (!(pte_en && pte_addr2 != 32'd0) && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            chk("reach_l0", 32'(pte_en && pte_addr2 != 32'd0), 32'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_flush();
        mptr = 0;
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_pte_en", 32'(pte_en), 32'd0);
        issue(32'h0040_2000, 1'b0, 1'b0, S, 1'b0);

        for (int i = 0; i < 8; i++) mem_wr(32'h10000 + 32'(4 * i), gen_l1());
        for (int t = 0; t < 3; t++)
            for (int j = 0; j < 8; j++)
                mem_wr(32'h11000 + 32'(t * 4096 + 4 * j), gen_l0());
        do_sfence();
        for (int n = 0; n < 200; n++) begin
            logic [31:0] va;
            va = (32'($urandom_range(0, 7)) << 22)
               | (32'($urandom_range(0, 7)) << 12)
               | 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 15) == 0) do_sfence();
            issue(va, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0,
                  ($urandom_range(0, 9) == 0) ? 32'h0000_0010 : S,
                  $urandom_range(0, 15) == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
